// File: rtl/fsm_sequencer.sv
// Walking-phase sequencer driven by the 4-bit FSM configuration word.
// Speed and mode are shadowed at start; enable is live and acts as abort.
module fsm_sequencer #(
  parameter int BASE_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       fsm_config,
  input  logic             pause,
  output logic [3:0]       phase,
  output logic             step_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int DIV_W = (BASE_DIV * 8 > 1) ? $clog2(BASE_DIV * 8) : 1;
  localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(BASE_DIV - 1);
  localparam logic [DIV_W-1:0] RELOAD1 = DIV_W'(BASE_DIV * 2 - 1);
  localparam logic [DIV_W-1:0] RELOAD2 = DIV_W'(BASE_DIV * 4 - 1);
  localparam logic [DIV_W-1:0] RELOAD3 = DIV_W'(BASE_DIV * 8 - 1);

  state_e             state_q, state_d;
  logic               en_q;
  logic               post_rst_q;
  logic               mode_q, mode_d;
  logic [1:0]         speed_q, speed_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         phase_q, phase_d;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   wrap_q, wrap_d;
  logic               busy_q, done_q;
  logic [DIV_W-1:0]   reload;
  logic [CNT_W-1:0]   wrap_inc;
  logic               start;

  always_comb begin
    case (speed_q)
      2'd0:    reload = RELOAD0;
      2'd1:    reload = RELOAD1;
      2'd2:    reload = RELOAD2;
      default: reload = RELOAD3;
    endcase
  end

  assign wrap_inc = (wrap_q == {CNT_W{1'b1}}) ? wrap_q : wrap_q + 1'b1;
  // The cycle right after reset is blocked so an enable held through reset is not an edge.
  assign start    = fsm_config[0] & ~en_q & ~post_rst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      post_rst_q <= 1'b1;
      mode_q     <= 1'b0;
      speed_q    <= 2'd0;
      cnt_q      <= '0;
      phase_q    <= 4'b0000;
      step_q     <= 1'b0;
      wrap_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= fsm_config[0];
      post_rst_q <= 1'b0;
      mode_q     <= mode_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      busy_q     <= (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_PAUSE);
      done_q     <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: begin
        phase_d = 4'b0000;
        if (start) begin
          state_d = S_ARM;
          mode_d  = fsm_config[1];
          speed_d = fsm_config[3:2];
        end
      end
      S_ARM: begin
        cnt_d   = reload;
        phase_d = 4'b0001;
        wrap_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!fsm_config[0]) begin
          state_d = S_IDLE;
          phase_d = 4'b0000;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (cnt_q == '0) begin
          cnt_d  = reload;
          step_d = 1'b1;
          if (phase_q[3]) begin
            wrap_d = wrap_inc;
            if (mode_q) begin
              phase_d = 4'b0001;
            end else begin
              phase_d = 4'b0000;
              state_d = S_DONE;
            end
          end else begin
            phase_d = {phase_q[2:0], phase_q[3]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PAUSE: begin
        if (!fsm_config[0]) begin
          state_d = S_IDLE;
          phase_d = 4'b0000;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        phase_d = 4'b0000;
        if (!fsm_config[0]) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 4'b0000;
      end
    endcase
  end

  assign phase      = phase_q;
  assign step_pulse = step_q;
  assign wrap_count = wrap_q;
  assign state      = state_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench for fsm_sequencer: reset, one-shot, continuous, pause,
// config shadowing and reset from PAUSE/DONE, with hand-computed expectations.
module tb_fsm_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fsm_config;
  logic       pause;
  logic [3:0] phase;
  logic       step_pulse;
  logic [7:0] wrap_count;
  logic [2:0] state;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  fsm_sequencer #(.BASE_DIV(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fsm_config (fsm_config),
    .pause      (pause),
    .phase      (phase),
    .step_pulse (step_pulse),
    .wrap_count (wrap_count),
    .state      (state),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; fsm_config = 4'b0001; pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if ({state, phase, step_pulse, wrap_count, busy, done} !== 18'd0) begin
        n_err++;
        $display("FAIL reset_vals cyc=%0d got st=%0d ph=%b sp=%b wc=%0d b=%b d=%b want all 0",
                 i, state, phase, step_pulse, wrap_count, busy, done);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if ({state, phase, busy} !== 8'd0) begin
        n_err++;
        $display("FAIL reset_no_start cyc=%0d got st=%0d ph=%b b=%b want 0/0000/0", i, state, phase, busy);
      end
    end
    fsm_config = 4'b0000;
    tick(1);
  endtask

  task automatic test_one_shot;
    logic [3:0] ep;
    logic [2:0] est;
    logic       es;
    fsm_config = 4'b0001;
    tick(1);
    n_cmp++;
    if ({state, phase, busy} !== {3'd1, 4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL os_arm got st=%0d ph=%b b=%b want 1/0000/1", state, phase, busy);
    end
    tick(1);
    n_cmp++;
    if ({state, phase, step_pulse, wrap_count} !== {3'd2, 4'b0001, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL os_load got st=%0d ph=%b sp=%b wc=%0d want 2/0001/0/0", state, phase, step_pulse, wrap_count);
    end
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      ep  = (i < 16) ? (4'b0001 << (i / 4)) : 4'b0000;
      est = (i < 16) ? 3'd2 : 3'd4;
      es  = (i % 4 == 0);
      n_cmp++;
      if ({state, phase, step_pulse} !== {est, ep, es}) begin
        n_err++;
        $display("FAIL os_walk i=%0d got st=%0d ph=%b sp=%b want %0d/%b/%b", i, state, phase, step_pulse, est, ep, es);
      end
    end
    n_cmp++;
    if ({done, busy, wrap_count} !== {1'b1, 1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL os_done got d=%b b=%b wc=%0d want 1/0/1", done, busy, wrap_count);
    end
  endtask

  task automatic test_continuous;
    logic [3:0] ep;
    logic [7:0] ew;
    logic       es;
    fsm_config = 4'b0000;
    tick(1);
    n_cmp++;
    if ({state, done, wrap_count} !== {3'd0, 1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL cont_idle got st=%0d d=%b wc=%0d want 0/0/1", state, done, wrap_count);
    end
    fsm_config = 4'b0111;
    tick(2);
    for (int i = 1; i <= 64; i++) begin
      tick(1);
      ep = 4'b0001 << ((i / 8) % 4);
      es = (i % 8 == 0);
      ew = 8'(i / 32);
      n_cmp++;
      if ({phase, step_pulse, wrap_count} !== {ep, es, ew}) begin
        n_err++;
        $display("FAIL cont_walk i=%0d got ph=%b sp=%b wc=%0d want %b/%b/%0d", i, phase, step_pulse, wrap_count, ep, es, ew);
      end
    end
    n_cmp++;
    if ({state, busy, done, wrap_count} !== {3'd2, 1'b1, 1'b0, 8'd2}) begin
      n_err++;
      $display("FAIL cont_end got st=%0d b=%b d=%b wc=%0d want 2/1/0/2", state, busy, done, wrap_count);
    end
  endtask

  task automatic test_pause;
    // 21 more cycles puts phase 0100 with the divider at 2
    tick(21);
    n_cmp++;
    if (phase !== 4'b0100) begin
      n_err++;
      $display("FAIL pause_pre got ph=%b want 0100", phase);
    end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_cmp++;
      if ({state, phase, step_pulse, wrap_count, busy} !== {3'd3, 4'b0100, 1'b0, 8'd2, 1'b1}) begin
        n_err++;
        $display("FAIL pause_hold i=%0d got st=%0d ph=%b sp=%b wc=%0d b=%b want 3/0100/0/2/1",
                 i, state, phase, step_pulse, wrap_count, busy);
      end
    end
    pause = 1'b0;
    tick(1);
    n_cmp++;
    if ({state, phase} !== {3'd2, 4'b0100}) begin
      n_err++;
      $display("FAIL pause_resume got st=%0d ph=%b want 2/0100", state, phase);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      n_cmp++;
      if ({phase, step_pulse} !== ((i == 3) ? 5'b1000_1 : 5'b0100_0)) begin
        n_err++;
        $display("FAIL pause_after i=%0d got ph=%b sp=%b", i, phase, step_pulse);
      end
    end
  endtask

  task automatic test_config_shadow;
    logic [3:0] ep;
    logic [7:0] ew;
    logic       es;
    fsm_config = 4'b1101;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      ep = 4'b0001 << ((3 + i / 8) % 4);
      ew = (i >= 8) ? 8'd3 : 8'd2;
      es = (i % 8 == 0);
      n_cmp++;
      if ({state, phase, step_pulse, wrap_count} !== {3'd2, ep, es, ew}) begin
        n_err++;
        $display("FAIL shadow_walk i=%0d got st=%0d ph=%b sp=%b wc=%0d want 2/%b/%b/%0d",
                 i, state, phase, step_pulse, wrap_count, ep, es, ew);
      end
    end
    fsm_config = 4'b0000;
    tick(1);
    n_cmp++;
    if ({state, phase, step_pulse, wrap_count, busy} !== {3'd0, 4'b0000, 1'b0, 8'd3, 1'b0}) begin
      n_err++;
      $display("FAIL abort got st=%0d ph=%b sp=%b wc=%0d b=%b want 0/0000/0/3/0",
               state, phase, step_pulse, wrap_count, busy);
    end
    fsm_config = 4'b1101;
    tick(2);
    n_cmp++;
    if ({state, phase, wrap_count} !== {3'd2, 4'b0001, 8'd0}) begin
      n_err++;
      $display("FAIL restart got st=%0d ph=%b wc=%0d want 2/0001/0", state, phase, wrap_count);
    end
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      ep = (i < 32) ? 4'b0001 : 4'b0010;
      es = (i == 32);
      n_cmp++;
      if ({phase, step_pulse} !== {ep, es}) begin
        n_err++;
        $display("FAIL slow_walk i=%0d got ph=%b sp=%b want %b/%b", i, phase, step_pulse, ep, es);
      end
    end
  endtask

  task automatic test_reset_pause;
    pause = 1'b1;
    tick(1);
    n_cmp++;
    if ({state, phase} !== {3'd3, 4'b0010}) begin
      n_err++;
      $display("FAIL rp_enter got st=%0d ph=%b want 3/0010", state, phase);
    end
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({state, phase, step_pulse, wrap_count, busy, done} !== 18'd0) begin
      n_err++;
      $display("FAIL rp_reset got st=%0d ph=%b sp=%b wc=%0d b=%b d=%b want all 0",
               state, phase, step_pulse, wrap_count, busy, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if ({state, phase, busy} !== 8'd0) begin
        n_err++;
        $display("FAIL rp_no_start cyc=%0d got st=%0d ph=%b b=%b want 0/0000/0", i, state, phase, busy);
      end
    end
  endtask

  task automatic test_reset_done;
    pause = 1'b0;
    fsm_config = 4'b0000;
    tick(1);
    fsm_config = 4'b0001;
    tick(18);
    n_cmp++;
    if ({state, done, busy, wrap_count} !== {3'd4, 1'b1, 1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL rd_done got st=%0d d=%b b=%b wc=%0d want 4/1/0/1", state, done, busy, wrap_count);
    end
    reset = 1'b1;
    pause = 1'b1;
    tick(1);
    n_cmp++;
    if ({state, phase, step_pulse, wrap_count, busy, done} !== 18'd0) begin
      n_err++;
      $display("FAIL rd_reset got st=%0d ph=%b sp=%b wc=%0d b=%b d=%b want all 0",
               state, phase, step_pulse, wrap_count, busy, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if ({state, busy, done} !== 5'd0) begin
        n_err++;
        $display("FAIL rd_no_start cyc=%0d got st=%0d b=%b d=%b want 0/0/0", i, state, busy, done);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    fsm_config = 4'b0000;
    pause = 1'b0;
    test_reset;
    test_one_shot;
    test_continuous;
    test_pause;
    test_config_shadow;
    test_reset_pause;
    test_reset_done;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_sequencer.md
Name: fsm_sequencer

Overview:
- Downstream consumer of the 4-bit memory-mapped FSM configuration word that the CPU writes at 0x1000_0000.
- Decodes the word into enable, mode and speed fields, then runs a walking-phase sequencer.
- Emits one-hot phase outputs, step strobes, a wrap counter and busy/done status for the rest of the tiny-FSM datapath.
- Config fields other than enable are shadowed at start, so CPU rewrites never glitch a sequence in flight.

Parameters:
- BASE_DIV, 4, clock cycles per phase step at speed select 0 (must be >= 1).
- CNT_W, 8, width of the wrap counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- fsm_config  input  4  [0] enable (level), [1] continuous (1) / one-shot (0), [3:2] speed select.
- pause  input  1  level; holds sequencer while in RUN.
- phase  output  4  one-hot walking phase; 0000 when not running.
- step_pulse  output  1  one-cycle strobe, coincident with each phase advance.
- wrap_count  output  CNT_W  completed 4-phase rotations since last start; saturates at all-ones.
- state  output  3  encoded state: IDLE=0, ARM=1, RUN=2, PAUSE=3, DONE=4.
- busy  output  1  high in ARM, RUN and PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Reset (sampled at posedge clk, overrides all else):
  - state=IDLE, phase=0000, step_pulse=0, wrap_count=0, busy=0, done=0.
  - Shadow config cleared. en_q (registered fsm_config[0]) cleared.
- Divider: div = BASE_DIV << fsm_config[3:2], shadowed at start. Divider counter width must hold BASE_DIV*8-1.
- Start edge: fsm_config[0]=1 while en_q=0.
- IDLE:
  - phase=0.
  - On a start edge: next state ARM; latch fsm_config[3:1] into shadow.
  - Enable held high from reset does not start; a rising edge is required.
- ARM (exactly 1 cycle):
  - Load divider counter = div-1, phase=0001, wrap_count=0.
  - Next state RUN. No step_pulse on this load.
- RUN:
  - Divider decrements each cycle.
  - At 0: reload div-1, rotate phase left (1000 wraps to 0001), step_pulse=1 that cycle.
  - On the 1000->0001 wrap: wrap_count increments (saturating).
  - One-shot: the advance out of 1000 goes to DONE instead of wrapping. phase goes to 0000, wrap_count increments, step_pulse=1.
- PAUSE:
  - Divider, phase and wrap_count frozen. step_pulse=0.
  - pause=0 returns to RUN and resumes the frozen divider value.
- DONE:
  - phase=0000, done=1, wrap_count held.
  - fsm_config[0]=0 returns to IDLE. A new start requires a fresh rising edge.
- Priority in RUN/PAUSE: fsm_config[0]=0 (abort) > pause > counting.
  - Abort: next state IDLE, phase=0000, wrap_count held, no step_pulse.
  - pause in IDLE, ARM or DONE is ignored. ARM always proceeds to RUN; pause is honoured from the first RUN cycle.
- Mid-sequence writes to fsm_config[3:1] are ignored until the next start edge.
- All outputs are registered. Start edge to phase=0001 is 2 cycles: IDLE->ARM, then ARM load visible.
- Reset asserted mid-sequence returns to IDLE next edge with all reset values.

Test Plan:
- Reset held 3 cycles with fsm_config=4'b0001 -> all outputs 0, state=0; after release with enable still high, stays IDLE (no edge).
- BASE_DIV=4, write 4'b0001 (one-shot, sel 0) after 0 -> phase 0001 for 4 cycles, then 0010, 0100, 1000; step_pulse at each change; after 16 RUN cycles done=1, wrap_count=1, busy=0.
- Write 4'b0111 (continuous, sel 1, div=8) -> phase advances every 8 cycles; after 64 RUN cycles wrap_count=2, busy=1, done=0.
- During RUN at phase 0100 with divider at 2, assert pause for 10 cycles -> state=3, outputs frozen; release -> phase 1000 exactly 3 cycles later.
- Continuous run: write 4'b1101 mid-sequence -> step period unchanged. Then write 4'b0000 -> next cycle IDLE, phase=0000, wrap_count held. Then rewrite 4'b1101 -> new period 4<<3=32 cycles.
- Assert reset during PAUSE and again in DONE -> next cycle IDLE with all reset values; pause high and enable high do not cause a restart.
